// File: rtl/seg7_reader.sv
// seg7_reader: samples a 7-segment pattern, waits for it to hold steady for
// STABLE_CYCLES consecutive matching samples, then decodes it to a hex digit.
// Illegal nonzero patterns that hold steady raise a one-cycle pattern_err.
// Optional feature (macro SEG7_READER_SEQ_CHECK_EN): checks that each legal
// digit is the previous legal digit plus one (mod 16). A violation raises
// seq_err and increments a saturating err_count.
// Handshake: there is no valid/ready pair here. new_digit, pattern_err and
// seq_err are single-cycle strobes. digit/digit_valid are level outputs that
// stay stable between strobes.
module seg7_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       new_digit,
    output logic       pattern_err,
    output logic       seq_err,
    output logic [7:0] err_count,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [6:0] seg_q;
    logic [3:0] digit_q, digit_d;
    logic       valid_q, valid_d;
    logic       new_q, new_d;
    logic       perr_q, perr_d;
    logic       match;
    logic       dec_legal;
    logic [3:0] dec_val;

    assign match = (seg_in == seg_q);

    // Decode the live pattern into a hex value plus a legality flag
    always_comb begin
        dec_legal = 1'b1;
        dec_val   = 4'h0;
        case (seg_in)
            7'h3F: dec_val = 4'h0;
            7'h06: dec_val = 4'h1;
            7'h5B: dec_val = 4'h2;
            7'h4F: dec_val = 4'h3;
            7'h66: dec_val = 4'h4;
            7'h6D: dec_val = 4'h5;
            7'h7D: dec_val = 4'h6;
            7'h07: dec_val = 4'h7;
            7'h7F: dec_val = 4'h8;
            7'h6F: dec_val = 4'h9;
            7'h77: dec_val = 4'hA;
            7'h7C: dec_val = 4'hB;
            7'h39: dec_val = 4'hC;
            7'h5E: dec_val = 4'hD;
            7'h79: dec_val = 4'hE;
            7'h71: dec_val = 4'hF;
            default: dec_legal = 1'b0;
        endcase
    end

    // Next-state and next-output logic; LOCKED with a matching sample holds everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        valid_d = valid_q;
        new_d   = 1'b0;
        perr_d  = 1'b0;
        if (seg_in == 7'h00) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
            valid_d = 1'b0;
        end else if (!match || state_q == IDLE) begin
            // IDLE implies seg_q is zero, so a nonzero input there is always a change
            state_d = SETTLE;
            cnt_d   = 8'd0;
            valid_d = 1'b0;
        end else if (state_q == SETTLE) begin
            if (cnt_q == LAST_CNT) begin
                state_d = LOCKED;
                if (dec_legal) begin
                    digit_d = dec_val;
                    valid_d = 1'b1;
                    new_d   = 1'b1;
                end else begin
                    valid_d = 1'b0;
                    perr_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // State, sample history and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            seg_q   <= 7'h00;
            digit_q <= 4'h0;
            valid_q <= 1'b0;
            new_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_in;
            digit_q <= digit_d;
            valid_q <= valid_d;
            new_q   <= new_d;
            perr_q  <= perr_d;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = valid_q;
    assign new_digit   = new_q;
    assign pattern_err = perr_q;
    assign state_dbg   = state_q;

`ifdef SEG7_READER_SEQ_CHECK_EN
    logic [3:0] prev_q;
    logic       prev_valid_q;
    logic       seq_q;
    logic [7:0] err_q;
    logic [3:0] prev_next;

    assign prev_next = prev_q + 4'd1;

    // Track the last legal digit and flag out-of-order legal locks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q       <= 4'h0;
            prev_valid_q <= 1'b0;
            seq_q        <= 1'b0;
            err_q        <= 8'h00;
        end else begin
            seq_q <= 1'b0;
            if (new_d) begin
                if (prev_valid_q && dec_val != prev_next) begin
                    seq_q <= 1'b1;
                    if (err_q != 8'hFF) begin
                        err_q <= err_q + 8'd1;
                    end
                end
                prev_q       <= dec_val;
                prev_valid_q <= 1'b1;
            end
        end
    end

    assign seq_err   = seq_q;
    assign err_count = err_q;
`else
    assign seq_err   = 1'b0;
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: two instances (STABLE_CYCLES=4 and =1) share one
// input. A run-length model predicts every output on each cycle. Directed
// sequences add literal expectations for the default instance.
module tb_seg7_reader;

    logic       clk;
    logic       rst;
    logic       chk_en;
    logic [6:0] seg_in;

    logic [3:0] digit_o     [2];
    logic       valid_o     [2];
    logic       new_o       [2];
    logic       perr_o      [2];
    logic       seq_o       [2];
    logic [7:0] errc_o      [2];
    logic [1:0] state_o     [2];

    int checks   = 0;
    int failures = 0;

    seg7_reader #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in),
        .digit(digit_o[0]), .digit_valid(valid_o[0]), .new_digit(new_o[0]),
        .pattern_err(perr_o[0]), .seq_err(seq_o[0]), .err_count(errc_o[0]),
        .state_dbg(state_o[0])
    );

    seg7_reader #(.STABLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .seg_in(seg_in),
        .digit(digit_o[1]), .digit_valid(valid_o[1]), .new_digit(new_o[1]),
        .pattern_err(perr_o[1]), .seq_err(seq_o[1]), .err_count(errc_o[1]),
        .state_dbg(state_o[1])
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

`ifdef SEG7_READER_SEQ_CHECK_EN
    localparam bit SEQ_ON = 1'b1;
`else
    localparam bit SEQ_ON = 1'b0;
`endif

    // ---------------- reference model ----------------
    logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic int stab(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // Returns the hex value, or -1 when the pattern is not a legal digit.
    function automatic int lookup(input logic [6:0] p);
        int r;
        r = -1;
        for (int j = 0; j < 16; j++) begin
            if (lut[j] == p) r = j;
        end
        return r;
    endfunction

    logic [6:0] m_last   [2];
    int         m_run    [2];
    logic [3:0] m_digit  [2];
    logic       m_valid  [2];
    logic       m_new    [2];
    logic       m_perr   [2];
    logic       m_seq    [2];
    logic [7:0] m_errc   [2];
    logic [3:0] m_prev   [2];
    logic       m_prev_ok[2];

    // A pattern locks when its run of identical samples reaches STABLE_CYCLES+1
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_last[i] = 7'h00; m_run[i] = 0; m_digit[i] = 4'h0; m_valid[i] = 1'b0;
                m_new[i] = 1'b0; m_perr[i] = 1'b0; m_seq[i] = 1'b0; m_errc[i] = 8'h00;
                m_prev[i] = 4'h0; m_prev_ok[i] = 1'b0;
            end else begin
                int v;
                if (seg_in == m_last[i]) begin
                    if (m_run[i] < 1000) m_run[i] = m_run[i] + 1;
                end else begin
                    m_run[i] = 1;
                end
                m_last[i] = seg_in;
                m_new[i] = 1'b0; m_perr[i] = 1'b0; m_seq[i] = 1'b0;
                v = lookup(seg_in);
                if (seg_in == 7'h00) begin
                    m_valid[i] = 1'b0;
                end else if (m_run[i] == stab(i) + 1) begin
                    if (v >= 0) begin
                        m_digit[i] = 4'(v);
                        m_valid[i] = 1'b1;
                        m_new[i]   = 1'b1;
                        if (SEQ_ON) begin
                            if (m_prev_ok[i] && v != ((int'(m_prev[i]) + 1) % 16)) begin
                                m_seq[i] = 1'b1;
                                if (m_errc[i] < 8'hFF) m_errc[i] = m_errc[i] + 8'd1;
                            end
                            m_prev[i] = 4'(v);
                            m_prev_ok[i] = 1'b1;
                        end
                    end else begin
                        m_valid[i] = 1'b0;
                        m_perr[i]  = 1'b1;
                    end
                end else if (m_run[i] < stab(i) + 1) begin
                    m_valid[i] = 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, compare both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("u%0d_digit", i),       16'(digit_o[i]), 16'(m_digit[i]));
                check($sformatf("u%0d_digit_valid", i), 16'(valid_o[i]), 16'(m_valid[i]));
                check($sformatf("u%0d_new_digit", i),   16'(new_o[i]),   16'(m_new[i]));
                check($sformatf("u%0d_pattern_err", i), 16'(perr_o[i]),  16'(m_perr[i]));
                check($sformatf("u%0d_seq_err", i),     16'(seq_o[i]),   16'(m_seq[i]));
                check($sformatf("u%0d_err_count", i),   16'(errc_o[i]),  16'(m_errc[i]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [6:0] val, input int n);
        seg_in = val;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        seg_in = 7'h00;
        tick();
        rst = 1'b0;
    endtask

    // Literal expectations for the default instance: lock on edge lock_k (0 = never)
    task automatic hold_expect(input logic [6:0] val, input int n, input int lock_k,
                               input bit legal, input bit seq_exp);
        seg_in = val;
        for (int k = 1; k <= n; k++) begin
            tick();
            check("lit_new_digit",   16'(new_o[0]),  16'(legal && k == lock_k));
            check("lit_pattern_err", 16'(perr_o[0]), 16'(!legal && k == lock_k));
            check("lit_digit_valid", 16'(valid_o[0]), 16'(legal && lock_k != 0 && k >= lock_k));
            check("lit_seq_err",     16'(seq_o[0]),  16'(SEQ_ON && seq_exp && k == lock_k));
        end
    endtask

    // ---------------- directed stimulus ----------------
    logic [6:0] seq_pats [4] = '{7'h79, 7'h71, 7'h3F, 7'h5B};

    initial begin
        chk_en = 1'b0;
        seg_in = 7'h00;
        rst    = 1'b1;
        repeat (2) tick();
        chk_en = 1'b1;
        check("rst_digit",       16'(digit_o[0]), 16'h0);
        check("rst_digit_valid", 16'(valid_o[0]), 16'h0);
        check("rst_new_digit",   16'(new_o[0]),   16'h0);
        check("rst_err_count",   16'(errc_o[0]),  16'h0);
        rst = 1'b0;
        tick();

        // 06 held: single pulse on edge 5, digit 1
        hold_expect(7'h06, 6, 5, 1'b1, 1'b0);
        check("lock06_digit", 16'(digit_o[0]), 16'h1);
        check("lock06_valid", 16'(valid_o[0]), 16'h1);

        // 5B too short to lock, 4F locks on edge 5 (3 after 1 is out of order)
        hold(7'h00, 2);
        hold_expect(7'h5B, 3, 0, 1'b1, 1'b0);
        hold_expect(7'h4F, 6, 5, 1'b1, 1'b1);
        check("lock4F_digit", 16'(digit_o[0]), 16'h3);

        // illegal 7E: pattern_err once, digit kept
        hold(7'h00, 2);
        hold_expect(7'h7E, 6, 5, 1'b0, 1'b0);
        check("illegal_digit_kept", 16'(digit_o[0]), 16'h3);
        check("illegal_valid",      16'(valid_o[0]), 16'h0);

        // sequence E, F, 0, 2 from a fresh reset: only the 2 is out of order
        do_reset();
        for (int s = 0; s < 4; s++) begin
            hold(7'h00, 2);
            hold_expect(seq_pats[s], 6, 5, 1'b1, s == 3);
        end
        check("seq_digit",     16'(digit_o[0]), 16'h2);
        check("seq_err_count", 16'(errc_o[0]),  SEQ_ON ? 16'h1 : 16'h0);

        // reset during SETTLE at cnt=2, then full latency again
        hold(7'h00, 1);
        hold(7'h3F, 3);
        rst = 1'b1;
        tick();
        check("midrst_digit", 16'(digit_o[0]), 16'h0);
        check("midrst_valid", 16'(valid_o[0]), 16'h0);
        rst = 1'b0;
        hold_expect(7'h3F, 6, 5, 1'b1, 1'b0);
        check("midrst_lock_digit", 16'(digit_o[0]), 16'h0);

        // repeated 1 locks: every lock after the first is out of order
        do_reset();
        for (int n = 0; n < 258; n++) begin
            hold(7'h00, 1);
            hold(7'h06, 5);
            if (n == 255) check("sat_reach_ff", 16'(errc_o[0]), SEQ_ON ? 16'hFF : 16'h0);
        end
        check("sat_hold_ff",  16'(errc_o[0]), SEQ_ON ? 16'hFF : 16'h0);
        check("sat_hold_ff1", 16'(errc_o[1]), SEQ_ON ? 16'hFF : 16'h0);

        hold(7'h00, 2);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
